// File: rtl/operand_sel_ctrl_pkg.sv
// rtl/operand_sel_ctrl_pkg.sv - shared opcode constants and A-operand select encodings
//
// Purpose : RV32 major-opcode constants and the 2-bit ASEL_* encodings used by
//           the operand-select controller and its decoder.
// Ports   : none (package).
package operand_sel_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [1:0] ASEL_RS1  = 2'b00;
   localparam logic [1:0] ASEL_PC   = 2'b01;
   localparam logic [1:0] ASEL_ZERO = 2'b10;
   localparam logic [1:0] ASEL_FWD  = 2'b11;

endpackage

// File: rtl/asel_decode.sv
// rtl/asel_decode.sv - single-instruction operand-select decode
//
// Purpose : Purely combinational decode of one instruction word.
// Ports   : inst_i       instruction word
//           base_asel_o  A select before forwarding (RS1 / PC / ZERO)
//           uses_rs1_o   A operand comes from rs1 (forwarding candidate)
//           bsel_o       1 = immediate, 0 = rs2
//           writes_rd_o  instruction writes a non-x0 destination
//           is_load_o    instruction is a load
//           rd_o, rs1_o  register indices
module asel_decode
   import operand_sel_ctrl_pkg::*;
#(
   parameter int RD_W = 5
) (
   input  logic [31:0]     inst_i,
   output logic [1:0]      base_asel_o,
   output logic            uses_rs1_o,
   output logic            bsel_o,
   output logic            writes_rd_o,
   output logic            is_load_o,
   output logic [RD_W-1:0] rd_o,
   output logic [RD_W-1:0] rs1_o
);

   logic [6:0] opc;
   logic       wr_op;
   logic       unused_bits;

   assign opc         = inst_i[6:0];
   assign rd_o        = RD_W'(inst_i[11:7]);
   assign rs1_o       = RD_W'(inst_i[19:15]);
   assign unused_bits = ^{inst_i[31:20], inst_i[14:12]};

   always_comb begin
      base_asel_o = ASEL_RS1;
      uses_rs1_o  = 1'b0;
      bsel_o      = 1'b1;
      wr_op       = 1'b0;
      is_load_o   = 1'b0;
      case (opc)
         OPC_AUIPC:  begin base_asel_o = ASEL_PC;   wr_op = 1'b1; end
         OPC_JAL:    begin base_asel_o = ASEL_PC;   wr_op = 1'b1; end
         OPC_BRANCH: begin base_asel_o = ASEL_PC;                 end
         OPC_LUI:    begin base_asel_o = ASEL_ZERO; wr_op = 1'b1; end
         OPC_OP:     begin uses_rs1_o = 1'b1; bsel_o = 1'b0; wr_op = 1'b1; end
         OPC_OP_IMM: begin uses_rs1_o = 1'b1; wr_op = 1'b1; end
         OPC_LOAD:   begin uses_rs1_o = 1'b1; wr_op = 1'b1; is_load_o = 1'b1; end
         OPC_STORE:  begin uses_rs1_o = 1'b1; end
         OPC_JALR:   begin uses_rs1_o = 1'b1; wr_op = 1'b1; end
         default:    ;
      endcase
   end

   // x0 is never a real producer, so it must never be forwarded from.
   assign writes_rd_o = wr_op & (inst_i[11:7] != 5'd0);

endmodule

// File: rtl/operand_sel_ctrl.sv
// rtl/operand_sel_ctrl.sv - ID->EX operand-select controller with rs1 forwarding
//
// Purpose : Registers the operand selects of the accepted ID instruction into
//           EX, tracks in-flight producers and detects load-use hazards.
//           Forwarding and the load-use stall are built only when the macro
//           ASEL_FWD_EN is defined; otherwise ex_asel never selects 11.
// Ports   : clk, rst (async, active-high)
//           id_valid, id_inst, id_ready   ID handshake
//           ex_stall, flush               pipeline control
//           ex_valid, ex_asel, ex_fwd_idx, ex_bsel   registered EX selects
module operand_sel_ctrl
   import operand_sel_ctrl_pkg::*;
#(
   parameter int FWD_STAGES = 3,
   parameter int RD_W       = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_inst,
   output logic        id_ready,
   input  logic        ex_stall,
   input  logic        flush,
   output logic        ex_valid,
   output logic [1:0]  ex_asel,
   output logic [1:0]  ex_fwd_idx,
   output logic        ex_bsel
);

   logic [1:0]      dec_asel;
   logic            dec_uses_rs1;
   logic            dec_bsel;
   logic            dec_writes_rd;
   logic            dec_is_load;
   logic [RD_W-1:0] dec_rd;
   logic [RD_W-1:0] dec_rs1;

   asel_decode #(.RD_W(RD_W)) u_dec (
      .inst_i      (id_inst),
      .base_asel_o (dec_asel),
      .uses_rs1_o  (dec_uses_rs1),
      .bsel_o      (dec_bsel),
      .writes_rd_o (dec_writes_rd),
      .is_load_o   (dec_is_load),
      .rd_o        (dec_rd),
      .rs1_o       (dec_rs1)
   );

   logic       ex_valid_q;
   logic [1:0] ex_asel_q;
   logic [1:0] ex_fwd_idx_q;
   logic       ex_bsel_q;
   logic [1:0] asel_d;
   logic [1:0] fwd_idx_d;
   logic       load_use;
   logic       load_ex;

`ifdef ASEL_FWD_EN
   // Slot 0 mirrors the EX entry; slot k is k stages past EX.
   logic [RD_W-1:0] slot_rd_q [FWD_STAGES];
   logic            slot_wr_q [FWD_STAGES];
   logic            slot_ld_q [FWD_STAGES];
   logic            fwd_hit;
   logic [1:0]      fwd_slot;

   // Scan oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_slot = 2'd0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (slot_wr_q[k] && (slot_rd_q[k] == dec_rs1)) begin
            fwd_hit  = 1'b1;
            fwd_slot = 2'(k);
         end
      end
      if (!dec_uses_rs1 || (dec_rs1 == '0)) begin
         fwd_hit  = 1'b0;
         fwd_slot = 2'd0;
      end
   end

   // Load data is not ready in EX; hold ID one cycle so it forwards from slot 1.
   assign load_use  = id_valid & fwd_hit & (fwd_slot == 2'd0) & slot_ld_q[0];
   assign asel_d    = fwd_hit ? ASEL_FWD : dec_asel;
   assign fwd_idx_d = fwd_hit ? fwd_slot : 2'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < FWD_STAGES; k++) begin
            slot_rd_q[k] <= '0;
            slot_wr_q[k] <= 1'b0;
            slot_ld_q[k] <= 1'b0;
         end
      end else if (!ex_stall) begin
         for (int k = FWD_STAGES - 1; k > 0; k--) begin
            slot_rd_q[k] <= slot_rd_q[k-1];
            slot_wr_q[k] <= slot_wr_q[k-1];
            slot_ld_q[k] <= slot_ld_q[k-1];
         end
         slot_rd_q[0] <= dec_rd;
         slot_wr_q[0] <= load_ex & dec_writes_rd;
         slot_ld_q[0] <= load_ex & dec_is_load;
      end
   end
`else
   logic unused_fwd;

   assign load_use   = 1'b0;
   assign asel_d     = dec_asel;
   assign fwd_idx_d  = 2'd0;
   assign unused_fwd = ^{dec_uses_rs1, dec_writes_rd, dec_is_load, dec_rd, dec_rs1,
                         FWD_STAGES[0]};
`endif

   assign id_ready = !rst & !ex_stall & !load_use;
   // A flushed ID instruction is dropped even though the handshake is offered.
   assign load_ex  = id_valid & id_ready & !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_asel_q    <= ASEL_RS1;
         ex_fwd_idx_q <= 2'd0;
         ex_bsel_q    <= 1'b0;
      end else if (!ex_stall) begin
         ex_valid_q   <= load_ex;
         ex_asel_q    <= load_ex ? asel_d    : ASEL_RS1;
         ex_fwd_idx_q <= load_ex ? fwd_idx_d : 2'd0;
         ex_bsel_q    <= load_ex & dec_bsel;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_asel    = ex_asel_q;
   assign ex_fwd_idx = ex_fwd_idx_q;
   assign ex_bsel    = ex_bsel_q;

endmodule

// File: tb/tb_operand_sel_ctrl.sv
// tb/tb_operand_sel_ctrl.sv - directed self-checking bench for operand_sel_ctrl
module tb_operand_sel_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_inst;
   logic        id_ready;
   logic        ex_stall;
   logic        flush;
   logic        ex_valid;
   logic [1:0]  ex_asel;
   logic [1:0]  ex_fwd_idx;
   logic        ex_bsel;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] I_AUIPC  = 32'h0000_1397;
   localparam logic [31:0] I_LUI    = 32'h0000_1437;
   localparam logic [31:0] I_ADDI5  = 32'h0010_0293;
   localparam logic [31:0] I_ADD    = 32'h0052_8333;
   localparam logic [31:0] I_LW     = 32'h0000_A283;
   localparam logic [31:0] I_ADDI0  = 32'h0010_8013;
   localparam logic [31:0] I_ADDX0  = 32'h0000_0333;

`ifdef ASEL_FWD_EN
   localparam logic [1:0] FWD_SEL = 2'b11;
   localparam logic [1:0] FWD_I1  = 2'd1;
`else
   localparam logic [1:0] FWD_SEL = 2'b00;
   localparam logic [1:0] FWD_I1  = 2'd0;
`endif

   operand_sel_ctrl #(.FWD_STAGES(3), .RD_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_inst    (id_inst),
      .id_ready   (id_ready),
      .ex_stall   (ex_stall),
      .flush      (flush),
      .ex_valid   (ex_valid),
      .ex_asel    (ex_asel),
      .ex_fwd_idx (ex_fwd_idx),
      .ex_bsel    (ex_bsel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ex(input string tag, input logic v, input logic [1:0] a,
                           input logic [1:0] f, input logic b);
      check({tag, ".valid"}, 32'(ex_valid), 32'(v));
      check({tag, ".asel"},  32'(ex_asel),  32'(a));
      check({tag, ".fwd"},   32'(ex_fwd_idx), 32'(f));
      check({tag, ".bsel"},  32'(ex_bsel),  32'(b));
   endtask

   task automatic idle(input int n);
      id_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_inst = 32'h0; ex_stall = 1'b0; flush = 1'b0;
      #2;
      check_ex("reset", 1'b0, 2'b00, 2'd0, 1'b0);
      check("reset.id_ready", 32'(id_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_reset.id_ready", 32'(id_ready), 32'd1);

      // AUIPC then LUI
      id_valid = 1'b1; id_inst = I_AUIPC;
      tick();
      check_ex("auipc", 1'b1, 2'b01, 2'd0, 1'b1);
      id_inst = I_LUI;
      tick();
      check_ex("lui", 1'b1, 2'b10, 2'd0, 1'b1);
      idle(1);
      check("bubble.valid", 32'(ex_valid), 32'd0);
      idle(3);

      // ADDI x5 then dependent ADD
      id_valid = 1'b1; id_inst = I_ADDI5;
      tick();
      check_ex("addi", 1'b1, 2'b00, 2'd0, 1'b1);
      id_inst = I_ADD;
      #1;
      check("addi_add.id_ready", 32'(id_ready), 32'd1);
      tick();
      check_ex("add_fwd0", 1'b1, FWD_SEL, 2'd0, 1'b0);
      idle(4);

      // LW x5 then ADD: load-use
      id_valid = 1'b1; id_inst = I_LW;
      tick();
      check_ex("lw", 1'b1, 2'b00, 2'd0, 1'b1);
      id_inst = I_ADD;
      #1;
`ifdef ASEL_FWD_EN
      check("loaduse.id_ready", 32'(id_ready), 32'd0);
      tick();
      check("loaduse.bubble", 32'(ex_valid), 32'd0);
      check("loaduse.id_ready_after", 32'(id_ready), 32'd1);
      tick();
      check_ex("loaduse.add", 1'b1, 2'b11, 2'd1, 1'b0);
`else
      check("loaduse.id_ready", 32'(id_ready), 32'd1);
      tick();
      check_ex("loaduse.add", 1'b1, 2'b00, 2'd0, 1'b0);
`endif
      idle(4);

      // ADDI x0 then ADD x6,x0,x0: x0 never forwards
      id_valid = 1'b1; id_inst = I_ADDI0;
      tick();
      id_inst = I_ADDX0;
      tick();
      check_ex("x0_nofwd", 1'b1, 2'b00, 2'd0, 1'b0);
      idle(4);

      // Stall with ADD waiting; flush during stall has no effect
      id_valid = 1'b1; id_inst = I_ADDI5;
      tick();
      id_inst = I_ADD; ex_stall = 1'b1;
      #1;
      check("stall.id_ready", 32'(id_ready), 32'd0);
      tick();
      check_ex("stall1", 1'b1, 2'b00, 2'd0, 1'b1);
      flush = 1'b1;
      tick();
      check_ex("stall2", 1'b1, 2'b00, 2'd0, 1'b1);
      tick();
      check_ex("stall3", 1'b1, 2'b00, 2'd0, 1'b1);
      ex_stall = 1'b0; flush = 1'b0;
      #1;
      check("release.id_ready", 32'(id_ready), 32'd1);
      tick();
      check_ex("release.add", 1'b1, FWD_SEL, 2'd0, 1'b0);
      idle(4);

      // Flush without stall: bubble enters, history still shifts
      id_valid = 1'b1; id_inst = I_ADDI5;
      tick();
      id_inst = I_ADD; flush = 1'b1;
      tick();
      check("flush.valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;
      tick();
      check_ex("flush.add", 1'b1, FWD_SEL, FWD_I1, 1'b0);
      idle(4);

      // Reset during the load-use cycle
      id_valid = 1'b1; id_inst = I_LW;
      tick();
      id_inst = I_ADD;
      #1;
      rst = 1'b1;
      #1;
      check_ex("async_rst", 1'b0, 2'b00, 2'd0, 1'b0);
      check("async_rst.id_ready", 32'(id_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check_ex("post_rst.add", 1'b1, 2'b00, 2'd0, 1'b0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
